// File: rtl/countdown_pkg.sv
// Shared types and helpers for the MM:SS countdown timer.
package countdown_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Limit a loaded digit to its legal range (never above 9).
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] lim);
    logic [DIGIT_W-1:0] cap;
    cap = (lim > DIGIT_MAX) ? DIGIT_MAX : lim;
    return (d > cap) ? cap : d;
  endfunction

endpackage

// File: rtl/countdown_mmss_if.sv
// Control/load/display bundle for countdown_mmss. `blank` exists only with COUNTDOWN_BLINK_EN.
interface countdown_mmss_if;
  import countdown_pkg::*;

  logic               tick;
  logic               load;
  logic               start;
  logic               pause;
  logic [7:0]         load_min;
  logic [7:0]         load_sec;
  logic [DIGIT_W-1:0] sec_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] min_tens;
  logic               running;
  logic               done;
  logic               alarm;
`ifdef COUNTDOWN_BLINK_EN
  logic               blank;
`endif

  modport master (
    output tick, load, start, pause, load_min, load_sec,
    input  sec_ones, sec_tens, min_ones, min_tens, running, done, alarm
`ifdef COUNTDOWN_BLINK_EN
    , input blank
`endif
  );

  modport slave (
    input  tick, load, start, pause, load_min, load_sec,
    output sec_ones, sec_tens, min_ones, min_tens, running, done, alarm
`ifdef COUNTDOWN_BLINK_EN
    , output blank
`endif
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: load has priority, wraps 0 -> MAX when enabled.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX
) (
  input  logic               fastclock,
  input  logic               resetn,
  input  logic               en,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] q,
  output logic               zero
);

  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= (q == '0) ? MAX : q - DIGIT_W'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/countdown_mmss.sv
// MM:SS countdown timer core with load/start/pause FSM, sticky done and alarm pulse.
// Optional flashing-display support via COUNTDOWN_BLINK_EN (adds bus.blank).
module countdown_mmss
  import countdown_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5,
  parameter logic [DIGIT_W-1:0] MIN_TENS_MAX = 4'd9
) (
  input  logic                fastclock,
  input  logic                resetn,
  countdown_mmss_if.slave     bus
);

  state_e state_q, state_d;
  logic   running_q, done_q, alarm_q;
  logic   dec_en;
  logic   count_zero, count_one;
  logic [3:0] en;
  logic [3:0] zero;

  // Borrow chain: a digit steps only when every lower digit is wrapping from 0.
  assign dec_en = (state_q == ST_RUN) && bus.tick && !bus.load;
  assign en[0]  = dec_en;
  assign en[1]  = en[0] & zero[0];
  assign en[2]  = en[1] & zero[1];
  assign en[3]  = en[2] & zero[2];

  assign count_zero = &zero;
  assign count_one  = zero[3] & zero[2] & zero[1] & (bus.sec_ones == DIGIT_W'(1));

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .fastclock(fastclock), .resetn(resetn), .en(en[0]), .ld(bus.load),
    .ld_val(clamp_digit(bus.load_sec[3:0], DIGIT_MAX)),
    .q(bus.sec_ones), .zero(zero[0])
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .fastclock(fastclock), .resetn(resetn), .en(en[1]), .ld(bus.load),
    .ld_val(clamp_digit(bus.load_sec[7:4], SEC_TENS_MAX)),
    .q(bus.sec_tens), .zero(zero[1])
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .fastclock(fastclock), .resetn(resetn), .en(en[2]), .ld(bus.load),
    .ld_val(clamp_digit(bus.load_min[3:0], DIGIT_MAX)),
    .q(bus.min_ones), .zero(zero[2])
  );

  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .fastclock(fastclock), .resetn(resetn), .en(en[3]), .ld(bus.load),
    .ld_val(clamp_digit(bus.load_min[7:4], MIN_TENS_MAX)),
    .q(bus.min_tens), .zero(zero[3])
  );

  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: load beats start/pause, which beat tick; reaching 00:00 beats pause.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (bus.start && !count_zero) state_d = ST_RUN;
        ST_RUN: begin
          if (bus.tick && count_one) state_d = ST_DONE;
          else if (bus.pause)        state_d = ST_PAUSE;
        end
        ST_PAUSE: if (bus.start) state_d = ST_RUN;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      alarm_q   <= (state_q == ST_RUN) && (state_d == ST_DONE);
    end
  end

  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;

`ifdef COUNTDOWN_BLINK_EN
  logic blank_q, blank_d;

  // Flash only while frozen (PAUSE/DONE); any move to IDLE/RUN shows the digits.
  always_comb begin
    blank_d = blank_q;
    if (state_d == ST_IDLE || state_d == ST_RUN) begin
      blank_d = 1'b0;
    end else if (bus.tick && (state_q == ST_PAUSE || state_q == ST_DONE)) begin
      blank_d = !blank_q;
    end
  end

  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: directed scenarios plus random control traffic,
// checked every cycle against a seconds-count reference model.
module tb_countdown_mmss;

  logic fastclock = 1'b0;
  logic resetn    = 1'b0;

  countdown_mmss_if bus();

  countdown_mmss #(.SEC_TENS_MAX(4'd5), .MIN_TENS_MAX(4'd9)) dut (
    .fastclock(fastclock),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 fastclock = ~fastclock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: 0=idle 1=run 2=pause 3=done, count held as total seconds.
  int m_state = 0;
  int m_count = 0;
  bit m_alarm = 1'b0;
  bit m_blank = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int clampd(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [15:0] exp_bcd();
    int m, s;
    m = m_count / 60;
    s = m_count % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check_all();
    check_val("digits",  {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones}, exp_bcd());
    check_val("running", bus.running, m_state == 1);
    check_val("done",    bus.done,    m_state == 3);
    check_val("alarm",   bus.alarm,   m_alarm);
`ifdef COUNTDOWN_BLINK_EN
    check_val("blank",   bus.blank,   m_blank);
`endif
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_alarm = 0; m_blank = 0;
  endtask

  task automatic model_update(input bit ld, input bit st, input bit pa, input bit tk,
                              input logic [7:0] lm, input logic [7:0] ls);
    int mins, secs;
    m_alarm = 1'b0;
    if (ld) begin
      mins    = clampd(int'(lm[7:4]), 9) * 10 + clampd(int'(lm[3:0]), 9);
      secs    = clampd(int'(ls[7:4]), 5) * 10 + clampd(int'(ls[3:0]), 9);
      m_count = mins * 60 + secs;
      m_state = 0;
    end else begin
      case (m_state)
        0: if (st && m_count != 0) m_state = 1;
        1: begin
          if (tk) begin
            m_count--;
            if (m_count == 0) begin
              m_state = 3;
              m_alarm = 1'b1;
            end else if (pa) m_state = 2;
          end else if (pa) m_state = 2;
        end
        2: begin
          if (tk) m_blank = !m_blank;
          if (st) m_state = 1;
        end
        default: if (tk) m_blank = !m_blank;
      endcase
    end
    if (m_state == 0 || m_state == 1) m_blank = 1'b0;
  endtask

  task automatic step(input bit ld, input bit st, input bit pa, input bit tk,
                      input logic [7:0] lm = 8'h00, input logic [7:0] ls = 8'h00);
    bus.load = ld; bus.start = st; bus.pause = pa; bus.tick = tk;
    bus.load_min = lm; bus.load_sec = ls;
    @(posedge fastclock);
    model_update(ld, st, pa, tk, lm, ls);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic apply_reset();
    bus.load = 0; bus.start = 0; bus.pause = 0; bus.tick = 0;
    bus.load_min = 8'h00; bus.load_sec = 8'h00;
    resetn = 1'b0;
    #3;
    model_reset();
    check_all();
    @(negedge fastclock);
    resetn = 1'b1;
  endtask

  initial begin
    bus.load = 0; bus.start = 0; bus.pause = 0; bus.tick = 0;
    bus.load_min = 8'h00; bus.load_sec = 8'h00;
    #12;
    model_reset();
    check_all();
    @(negedge fastclock);
    resetn = 1'b1;

    // 00:03 down to done, alarm for one cycle only
    step(1, 0, 0, 0, 8'h00, 8'h03);
    step(0, 1, 0, 0);
    ticks(3);
    step(0, 0, 0, 0);
    // DONE ignores start, pause and tick
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Both borrow paths
    step(1, 0, 0, 0, 8'h10, 8'h00);
    step(0, 1, 0, 0);
    ticks(1);
    step(1, 0, 0, 0, 8'h01, 8'h00);
    step(0, 1, 0, 0);
    ticks(1);

    // Pause holds count, resume continues
    step(1, 0, 0, 0, 8'h05, 8'h30);
    step(0, 1, 0, 0);
    ticks(2);
    step(0, 0, 1, 0);
    ticks(5);
    step(0, 1, 0, 0);
    ticks(1);

    // Clamp of out-of-range load digits, then start in IDLE with tick together
    step(1, 0, 0, 0, 8'hAF, 8'h7C);
    step(0, 1, 0, 1);
    ticks(1);

    // Start at 00:00 stays in IDLE
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 1);

    // Pause and tick together, then DONE wins over pause
    step(1, 0, 0, 0, 8'h00, 8'h03);
    step(0, 1, 0, 0);
    ticks(1);
    step(0, 0, 1, 1);
    ticks(2);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    ticks(3);

    // Reset mid-count at 12:34
    step(1, 0, 0, 0, 8'h12, 8'h34);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    apply_reset();
    step(0, 0, 0, 0);

    // Random traffic, biased towards short counts so DONE is reached often
    for (int i = 0; i < 4000; i++) begin
      bit ld, st, pa, tk;
      logic [7:0] lm, ls;
      ld = ($urandom_range(39, 0) == 0);
      st = ($urandom_range(7, 0) == 0);
      pa = ($urandom_range(9, 0) == 0);
      tk = ($urandom_range(2, 0) == 0);
      if ($urandom_range(1, 0) == 0) begin
        lm = 8'h00;
        ls = 8'($urandom_range(8'h15, 0));
      end else begin
        lm = 8'($urandom);
        ls = 8'($urandom);
      end
      if ($urandom_range(499, 0) == 0) apply_reset();
      step(ld, st, pa, tk, lm, ls);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
